// File: rtl/if_id_queue_if.sv
// if_id_queue_if: handshake and redirect bundle between IF, the IF/ID queue and ID.
//   in_valid/in_ready/in_instr/in_pc    : IF -> queue beat
//   out_valid/out_ready/out_instr/out_pc: queue -> ID beat
//   flush                               : execute-stage discard request
//   redirect/redirect_pc                : queue -> IF early branch redirect
// Modports: master = environment (IF/ID/EX side), slave = the queue.
interface if_id_queue_if;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_instr;
   logic [31:0] in_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [31:0] out_pc;
   logic        flush;
   logic        redirect;
   logic [31:0] redirect_pc;

   modport master (
      output in_valid, in_instr, in_pc, out_ready, flush,
      input  in_ready, out_valid, out_instr, out_pc, redirect, redirect_pc
   );

   modport slave (
      input  in_valid, in_instr, in_pc, out_ready, flush,
      output in_ready, out_valid, out_instr, out_pc, redirect, redirect_pc
   );
endinterface

// File: rtl/if_id_queue.sv
// if_id_queue: two-entry IF->ID instruction queue with early resolution of
// unconditional relative branches and execute-stage flush.
// Ports:
//   clk    : clock, rising edge
//   rst    : asynchronous active-high reset
//   q_io   : if_id_queue_if.slave (IF beat in, ID beat out, flush in, redirect out)
// Parameter:
//   BR_OP  : instr[31:26] opcode of an unconditional relative branch
module if_id_queue #(
   parameter logic [5:0] BR_OP = 6'b110000
) (
   input logic           clk,
   input logic           rst,
   if_id_queue_if.slave  q_io
);

   logic [31:0] instr_q [2];
   logic [31:0] pc_q    [2];
   logic        head_q, head_d;
   logic [1:0]  count_q, count_d;
   logic        redirect_q, redirect_d;
   logic [31:0] redirect_pc_q, redirect_pc_d;

   logic        accept;
   logic        is_branch;
   logic        live;
   logic        push;
   logic        pop;
   logic        br_take;
   logic        tail;
   logic [31:0] br_target;

   assign accept    = q_io.in_valid && q_io.in_ready;
   assign is_branch = (q_io.in_instr[31:26] == BR_OP);
   // Beats accepted under flush or in the redirect shadow are wrong-path.
   assign live      = accept && !q_io.flush && !redirect_q;
   assign push      = live && !is_branch;
   assign br_take   = live && is_branch;
   assign pop       = (count_q != 2'd0) && q_io.out_ready && !q_io.flush;
   // First free slot; with count 1 and a pop this is the slot the head moves to.
   assign tail      = head_q ^ count_q[0];
   assign br_target = q_io.in_pc + {{14{q_io.in_instr[15]}}, q_io.in_instr[15:0], 2'b00};

   always_comb begin
      count_d       = count_q;
      head_d        = head_q;
      redirect_d    = 1'b0;
      redirect_pc_d = redirect_pc_q;
      if (q_io.flush) begin
         count_d = 2'd0;
         head_d  = 1'b0;
      end else begin
         unique case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
         endcase
         if (pop) begin
            head_d = ~head_q;
         end
         if (br_take) begin
            redirect_d    = 1'b1;
            redirect_pc_d = br_target;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q       <= 2'd0;
         head_q        <= 1'b0;
         redirect_q    <= 1'b0;
         redirect_pc_q <= 32'd0;
      end else begin
         count_q       <= count_d;
         head_q        <= head_d;
         redirect_q    <= redirect_d;
         redirect_pc_q <= redirect_pc_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         instr_q[0] <= 32'd0;
         instr_q[1] <= 32'd0;
         pc_q[0]    <= 32'd0;
         pc_q[1]    <= 32'd0;
      end else if (push) begin
         instr_q[tail] <= q_io.in_instr;
         pc_q[tail]    <= q_io.in_pc;
      end
   end

   always_comb begin
      q_io.in_ready    = (count_q != 2'd2);
      q_io.out_valid   = (count_q != 2'd0);
      // Stale storage is masked so an empty queue always reads zero.
      q_io.out_instr   = q_io.out_valid ? instr_q[head_q] : 32'd0;
      q_io.out_pc      = q_io.out_valid ? pc_q[head_q] : 32'd0;
      q_io.redirect    = redirect_q;
      q_io.redirect_pc = redirect_pc_q;
   end

endmodule

// File: tb/tb_if_id_queue.sv
// tb_if_id_queue: table-driven directed bench for if_id_queue plus a hand-written
// asynchronous-reset sequence. Inputs change and outputs are sampled on the falling edge.
module tb_if_id_queue;

   logic clk;
   logic rst;

   if_id_queue_if bus ();

   if_id_queue #(
      .BR_OP (6'b110000)
   ) dut (
      .clk  (clk),
      .rst  (rst),
      .q_io (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        valid;
      logic [31:0] instr;
      logic [31:0] pc;
      logic        ordy;
      logic        flush;
      logic        e_ir;
      logic        e_ov;
      logic [31:0] e_pc;
      logic [31:0] e_instr;
      logic        e_rd;
      logic [31:0] e_rpc;
   } vec_t;

   vec_t vecs[$];
   int   n_pass;
   int   n_total;

   function automatic logic [31:0] nb(input logic [31:0] pc);
      return 32'h1000_0000 | pc;
   endfunction

   function automatic logic [31:0] br(input logic [15:0] imm);
      return {6'b110000, 10'd0, imm};
   endfunction

   task automatic add(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                      input logic ordy, input logic fl, input logic eir, input logic eov,
                      input logic [31:0] epc, input logic erd, input logic [31:0] erpc);
      vec_t r;
      r.valid = v;   r.instr = ins;  r.pc = pc;   r.ordy = ordy; r.flush = fl;
      r.e_ir = eir;  r.e_ov = eov;   r.e_pc = epc;
      r.e_instr = eov ? nb(epc) : 32'd0;
      r.e_rd = erd;  r.e_rpc = erpc;
      vecs.push_back(r);
   endtask

   task automatic chk(input string name, input int idx, input logic [31:0] act,
                      input logic [31:0] exp);
      n_total++;
      if (act !== exp)
         $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
      else
         n_pass++;
   endtask

   task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                        input logic ordy, input logic fl);
      bus.in_valid  = v;
      bus.in_instr  = ins;
      bus.in_pc     = pc;
      bus.out_ready = ordy;
      bus.flush     = fl;
   endtask

   initial begin
      n_pass  = 0;
      n_total = 0;
      rst     = 1'b1;
      drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);

      // stream with out_ready=1
      add(0, 0,         0,     0, 0,  1, 0, 32'h000, 0, 32'h0);
      add(1, nb(32'h0), 32'h0, 1, 0,  1, 0, 32'h000, 0, 32'h0);
      add(1, nb(32'h4), 32'h4, 1, 0,  1, 1, 32'h000, 0, 32'h0);
      add(1, nb(32'h8), 32'h8, 1, 0,  1, 1, 32'h004, 0, 32'h0);
      add(0, 0,         0,     1, 0,  1, 1, 32'h008, 0, 32'h0);
      add(0, 0,         0,     1, 0,  1, 0, 32'h000, 0, 32'h0);
      // fill under stall, then drain
      add(1, nb(32'h0), 32'h0, 0, 0,  1, 0, 32'h000, 0, 32'h0);
      add(1, nb(32'h4), 32'h4, 0, 0,  1, 1, 32'h000, 0, 32'h0);
      add(1, nb(32'h8), 32'h8, 0, 0,  0, 1, 32'h000, 0, 32'h0);
      add(1, nb(32'h8), 32'h8, 1, 0,  0, 1, 32'h000, 0, 32'h0);
      add(1, nb(32'h8), 32'h8, 1, 0,  1, 1, 32'h004, 0, 32'h0);
      add(0, 0,         0,     1, 0,  1, 1, 32'h008, 0, 32'h0);
      add(0, 0,         0,     1, 0,  1, 0, 32'h000, 0, 32'h0);
      // backward branch, shadow beat discarded
      add(1, br(16'hFFFE), 32'h100, 1, 0,  1, 0, 32'h0, 0, 32'h0);
      add(1, nb(32'h104),  32'h104, 1, 0,  1, 0, 32'h0, 1, 32'h0F8);
      add(0, 0,            0,       1, 0,  1, 0, 32'h0, 0, 32'h0F8);
      // back-to-back branches: only the first redirects
      add(1, br(16'h0004), 32'h200, 1, 0,  1, 0, 32'h0, 0, 32'h0F8);
      add(1, br(16'h0008), 32'h204, 1, 0,  1, 0, 32'h0, 1, 32'h210);
      add(0, 0,            0,       1, 0,  1, 0, 32'h0, 0, 32'h210);
      // target wraps past 2^32
      add(1, br(16'h0002), 32'hFFFF_FFFC, 1, 0,  1, 0, 32'h0, 0, 32'h210);
      add(0, 0,            0,             1, 0,  1, 0, 32'h0, 1, 32'h4);
      add(0, 0,            0,             1, 0,  1, 0, 32'h0, 0, 32'h4);
      // full queue flushed with a branch on the input
      add(1, nb(32'h300),  32'h300, 0, 0,  1, 0, 32'h000, 0, 32'h4);
      add(1, nb(32'h304),  32'h304, 0, 0,  1, 1, 32'h300, 0, 32'h4);
      add(1, br(16'h0001), 32'h308, 0, 1,  0, 1, 32'h300, 0, 32'h4);
      add(0, 0,            0,       0, 0,  1, 0, 32'h000, 0, 32'h4);
      // branch accepted together with flush: no redirect
      add(1, br(16'h0001), 32'h400, 0, 1,  1, 0, 32'h000, 0, 32'h4);
      add(0, 0,            0,       0, 0,  1, 0, 32'h000, 0, 32'h4);
      // flush with a beat on the input discards it too
      add(1, nb(32'h500),  32'h500, 0, 0,  1, 0, 32'h000, 0, 32'h4);
      add(0, 0,            0,       0, 0,  1, 1, 32'h500, 0, 32'h4);
      add(1, nb(32'h504),  32'h504, 0, 1,  1, 1, 32'h500, 0, 32'h4);
      add(0, 0,            0,       0, 0,  1, 0, 32'h000, 0, 32'h4);
      // pop proceeds during the redirect cycle
      add(1, nb(32'h600),  32'h600, 0, 0,  1, 0, 32'h000, 0, 32'h4);
      add(1, br(16'h0010), 32'h604, 0, 0,  1, 1, 32'h600, 0, 32'h4);
      add(0, 0,            0,       1, 0,  1, 1, 32'h600, 1, 32'h644);
      add(0, 0,            0,       1, 0,  1, 0, 32'h000, 0, 32'h644);

      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < vecs.size(); i++) begin
         if (i != 0) @(negedge clk);
         drive(vecs[i].valid, vecs[i].instr, vecs[i].pc, vecs[i].ordy, vecs[i].flush);
         #1;
         chk("in_ready",    i, {31'd0, bus.in_ready},  {31'd0, vecs[i].e_ir});
         chk("out_valid",   i, {31'd0, bus.out_valid}, {31'd0, vecs[i].e_ov});
         chk("out_pc",      i, bus.out_pc,             vecs[i].e_pc);
         chk("out_instr",   i, bus.out_instr,          vecs[i].e_instr);
         chk("redirect",    i, {31'd0, bus.redirect},  {31'd0, vecs[i].e_rd});
         chk("redirect_pc", i, bus.redirect_pc,        vecs[i].e_rpc);
      end

      // Asynchronous reset with one entry queued and a redirect in flight.
      @(negedge clk);
      drive(1'b1, nb(32'h700), 32'h700, 1'b0, 1'b0);
      @(negedge clk);
      drive(1'b1, br(16'h0010), 32'h704, 1'b0, 1'b0);
      @(posedge clk);
      #2;
      drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
      chk("pre_rst_redirect",    100, {31'd0, bus.redirect},  32'd1);
      chk("pre_rst_redirect_pc", 100, bus.redirect_pc,        32'h744);
      chk("pre_rst_out_pc",      100, bus.out_pc,             32'h700);
      rst = 1'b1;
      #1;
      chk("rst_out_valid",   101, {31'd0, bus.out_valid}, 32'd0);
      chk("rst_out_instr",   101, bus.out_instr,          32'd0);
      chk("rst_out_pc",      101, bus.out_pc,             32'd0);
      chk("rst_redirect",    101, {31'd0, bus.redirect},  32'd0);
      chk("rst_redirect_pc", 101, bus.redirect_pc,        32'd0);
      chk("rst_in_ready",    101, {31'd0, bus.in_ready},  32'd1);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_out_valid", 102, {31'd0, bus.out_valid}, 32'd0);
      chk("post_rst_redirect",  102, {31'd0, bus.redirect},  32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
